// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: active-high segment patterns (bit0=a .. bit6=g),
// segment bit positions and the capture FSM state encoding.
package seven_segment_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] HEX_0 = 7'h3F;
    localparam logic [6:0] HEX_1 = 7'h06;
    localparam logic [6:0] HEX_2 = 7'h5B;
    localparam logic [6:0] HEX_3 = 7'h4F;
    localparam logic [6:0] HEX_4 = 7'h66;
    localparam logic [6:0] HEX_5 = 7'h6D;
    localparam logic [6:0] HEX_6 = 7'h7D;
    localparam logic [6:0] HEX_7 = 7'h07;
    localparam logic [6:0] HEX_8 = 7'h7F;
    localparam logic [6:0] HEX_9 = 7'h6F;
    localparam logic [6:0] HEX_A = 7'h77;
    localparam logic [6:0] HEX_B = 7'h7C;
    localparam logic [6:0] HEX_C = 7'h39;
    localparam logic [6:0] HEX_D = 7'h5E;
    localparam logic [6:0] HEX_E = 7'h79;
    localparam logic [6:0] HEX_F = 7'h71;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETTLING = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        SETTLING = ST_SETTLING,
        HELD     = ST_HELD
    } capture_state_e;

    function automatic logic [6:0] hex_pattern(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'h0: pat = HEX_0;
            4'h1: pat = HEX_1;
            4'h2: pat = HEX_2;
            4'h3: pat = HEX_3;
            4'h4: pat = HEX_4;
            4'h5: pat = HEX_5;
            4'h6: pat = HEX_6;
            4'h7: pat = HEX_7;
            4'h8: pat = HEX_8;
            4'h9: pat = HEX_9;
            4'hA: pat = HEX_A;
            4'hB: pat = HEX_B;
            4'hC: pat = HEX_C;
            4'hD: pat = HEX_D;
            4'hE: pat = HEX_E;
            default: pat = HEX_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational inverse of the driver encoder: active-high pattern -> nibble,
// with flags for a legal hex glyph and for an all-off (blank) digit.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       legal_o,
    output logic       blank_o
);

    always_comb begin
        nibble_o = 4'h0;
        legal_o  = 1'b0;
        blank_o  = (pattern_i == SEG_BLANK);
        for (int n = 0; n < 16; n++) begin
            if (pattern_i == hex_pattern(4'(n))) begin
                nibble_o = 4'(n);
                legal_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of a multiplexed seven-segment bus: synchronizes and debounces the
// shared lines, decodes each enabled digit and publishes a coherent frame.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int DIGITS        = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic                  clock_i,
    input  logic                  resetN_i,
    input  logic [7:0]            segmentEnableN_i,
    input  logic [DIGITS-1:0]     digitEnableN_i,
    output logic [DIGITS*4-1:0]   data_o,
    output logic [DIGITS-1:0]     pointEnable_o,
    output logic [DIGITS-1:0]     digitValid_o,
    output logic                  frameValid_o,
    output logic                  frameStrobe_o,
    output logic                  errorFlag_o
);

    localparam int SW    = 8 + DIGITS;
    localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(SETTLE_CYCLES - 1);

    logic [SW-1:0]           sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]        stab_q, stab_d;
    capture_state_e          state_q, state_d;
    logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
    logic [DIGITS*4-1:0]     shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]       shadow_point_q, shadow_point_d;
    logic [DIGITS-1:0]       shadow_valid_q, shadow_valid_d;
    logic [DIGITS-1:0]       seen_q, seen_d;
    logic                    commit_q, commit_d;
    logic [DIGITS*4-1:0]     data_q, data_d;
    logic [DIGITS-1:0]       point_q, point_d;
    logic [DIGITS-1:0]       valid_q, valid_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    strobe_q, strobe_d;
    logic                    error_q, error_d;

    logic [7:0]        seg_s;
    logic [DIGITS-1:0] en_low;
    logic              changed, any_low, one_hot, act;
    logic [3:0]        dec_nibble;
    logic              dec_legal, dec_blank;

    assign seg_s   = sync2_q[7:0];
    assign en_low  = ~sync2_q[8 +: DIGITS];
    assign changed = (sync2_q != prev_q);
    assign any_low = |en_low;
    assign one_hot = any_low && ((en_low & (en_low - 1'b1)) == '0);
    assign act     = !changed && (state_q == SETTLING) && (stab_q == STAB_MAX);

    seven_segment_decoder u_decoder (
        .pattern_i (~seg_s[6:0]),
        .nibble_o  (dec_nibble),
        .legal_o   (dec_legal),
        .blank_o   (dec_blank)
    );

    always_comb begin
        stab_d         = stab_q;
        state_d        = state_q;
        wd_d           = wd_q + 1'b1;
        shadow_data_d  = shadow_data_q;
        shadow_point_d = shadow_point_q;
        shadow_valid_d = shadow_valid_q;
        seen_d         = seen_q;
        commit_d       = 1'b0;
        error_d        = 1'b0;
        data_d         = data_q;
        point_d        = point_q;
        valid_d        = valid_q;
        frame_valid_d  = frame_valid_q;
        strobe_d       = 1'b0;

        if (changed) begin
            stab_d  = '0;
            state_d = any_low ? SETTLING : IDLE;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + 1'b1;
        end

        // One action per stable value; HELD blocks repeats until the lines move.
        if (act) begin
            state_d = HELD;
            wd_d    = '0;
            if (one_hot) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (en_low[i]) begin
                        shadow_data_d[4*i +: 4] = dec_legal ? dec_nibble : 4'h0;
                        shadow_valid_d[i]       = dec_legal;
                        shadow_point_d[i]       = ~seg_s[SEG_DP];
                        seen_d[i]               = 1'b1;
                    end
                end
                error_d  = !dec_legal && !dec_blank;
                commit_d = &seen_d;
            end else begin
                error_d = 1'b1;
            end
        end

        // A commit outranks a coincident watchdog expiry and restarts it.
        if (commit_q) begin
            data_d        = shadow_data_q;
            point_d       = shadow_point_q;
            valid_d       = shadow_valid_q;
            frame_valid_d = 1'b1;
            strobe_d      = 1'b1;
            seen_d        = '0;
            wd_d          = '0;
        end else if ((&wd_q) && !act) begin
            frame_valid_d = 1'b0;
            seen_d        = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetN_i) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            prev_q         <= '0;
            stab_q         <= '0;
            state_q        <= IDLE;
            wd_q           <= '0;
            shadow_data_q  <= '0;
            shadow_point_q <= '0;
            shadow_valid_q <= '0;
            seen_q         <= '0;
            commit_q       <= 1'b0;
            data_q         <= '0;
            point_q        <= '0;
            valid_q        <= '0;
            frame_valid_q  <= 1'b0;
            strobe_q       <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            sync1_q        <= {digitEnableN_i, segmentEnableN_i};
            sync2_q        <= sync1_q;
            prev_q         <= sync2_q;
            stab_q         <= stab_d;
            state_q        <= state_d;
            wd_q           <= wd_d;
            shadow_data_q  <= shadow_data_d;
            shadow_point_q <= shadow_point_d;
            shadow_valid_q <= shadow_valid_d;
            seen_q         <= seen_d;
            commit_q       <= commit_d;
            data_q         <= data_d;
            point_q        <= point_d;
            valid_q        <= valid_d;
            frame_valid_q  <= frame_valid_d;
            strobe_q       <= strobe_d;
            error_q        <= error_d;
        end
    end

    assign data_o        = data_q;
    assign pointEnable_o = point_q;
    assign digitValid_o  = valid_q;
    assign frameValid_o  = frame_valid_q;
    assign frameStrobe_o = strobe_q;
    assign errorFlag_o   = error_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: stimulus queues expected frames and error
// pulses, a monitor pops and compares them whenever the DUT strobes.
module tb_seven_segment_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg;
    logic [7:0]  en;
    logic [31:0] data;
    logic [7:0]  point, dvalid;
    logic        frame_valid, frame_strobe, error_flag;

    always #5 clk = ~clk;

    seven_segment_capture #(
        .DIGITS(8), .SETTLE_CYCLES(16), .TIMEOUT_BITS(8)
    ) dut (
        .clock_i          (clk),
        .resetN_i         (rst_n),
        .segmentEnableN_i (seg),
        .digitEnableN_i   (en),
        .data_o           (data),
        .pointEnable_o    (point),
        .digitValid_o     (dvalid),
        .frameValid_o     (frame_valid),
        .frameStrobe_o    (frame_strobe),
        .errorFlag_o      (error_flag)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  point;
        logic [7:0]  valid;
    } frame_t;

    frame_t exp_frames[$];
    int     exp_errs[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     strobes = 0;
    int     last_strobe_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] pat(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
            4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
            4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
            4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
        endcase
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, got, cyc);
        end
    endtask

    task automatic show_raw(input int k, input logic [7:0] s, input int n);
        en  = ~(8'd1 << k);
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int k, input logic [3:0] nib, input logic dp, input int n);
        show_raw(k, ~{dp, pat(nib)}, n);
    endtask

    task automatic go_idle(input int n);
        en  = 8'hFF;
        seg = 8'hFF;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [31:0] d, input logic [7:0] p, input logic [7:0] v);
        frame_t f;
        f.data = d; f.point = p; f.valid = v;
        exp_frames.push_back(f);
    endtask

    // Monitor: every strobe/error pulse is matched against the scoreboard queues.
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frame_strobe) begin
                    strobes++;
                    last_strobe_cyc = cyc;
                    check("frame_expected", 32'(exp_frames.size() > 0), 32'd1);
                    if (exp_frames.size() > 0) begin
                        f = exp_frames.pop_front();
                        check("frame_data", data, f.data);
                        check("frame_point", 32'(point), 32'(f.point));
                        check("frame_digit_valid", 32'(dvalid), 32'(f.valid));
                        check("frame_valid_flag", 32'(frame_valid), 32'd1);
                    end
                end
                if (error_flag) begin
                    check("error_expected", 32'(exp_errs.size() > 0), 32'd1);
                    if (exp_errs.size() > 0) void'(exp_errs.pop_front());
                end
            end
        end
    end

    initial begin
        int saved;
        int target;

        // Reset with random inputs
        rst_n = 1'b0;
        seg   = 8'($urandom);
        en    = 8'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_data", data, 32'h0);
        check("reset_digit_valid", 32'(dvalid), 32'h0);
        check("reset_frame_valid", 32'(frame_valid), 32'h0);
        check("reset_strobe", 32'(frame_strobe), 32'h0);
        check("reset_error", 32'(error_flag), 32'h0);
        seg = 8'hFF;
        en  = 8'hFF;
        @(posedge clk);
        #1 rst_n = 1'b1;
        go_idle(5);

        // Frame 1..8 with dp on digit 0
        expect_frame(32'h87654321, 8'h01, 8'hFF);
        for (int i = 0; i < 8; i++) show(i, 4'(i + 1), i == 0, 40);
        check("t2_frame_valid", 32'(frame_valid), 32'd1);
        check("t2_strobe_count", strobes, 1);

        // Digit 2 too short first: no commit until it is held long enough
        saved = strobes;
        show(0, 4'h9, 1'b0, 40);
        show(1, 4'hA, 1'b0, 40);
        show(2, 4'hB, 1'b0, 10);
        for (int i = 3; i < 8; i++) show(i, 4'((i + 9) & 15), 1'b0, 40);
        check("t3_no_early_commit", strobes, saved);
        expect_frame(32'h0FEDCBA9, 8'h00, 8'hFF);
        show(2, 4'hB, 1'b0, 40);
        check("t3_commit_after_hold", strobes, saved + 1);

        // Multi-hot enables in the middle of a frame
        for (int i = 0; i < 4; i++) show(i, 4'(i + 1), i == 3, 40);
        exp_errs.push_back(4);
        en  = 8'hFC;
        seg = ~{1'b0, pat(4'hE)};
        repeat (30) @(posedge clk);
        #1;
        check("t4_error_seen", exp_errs.size(), 0);
        expect_frame(32'h87654321, 8'h08, 8'hFF);
        for (int i = 4; i < 8; i++) show(i, 4'(i + 1), 1'b0, 40);

        // Illegal pattern on digit 3
        exp_errs.push_back(5);
        expect_frame(32'h76540210, 8'h00, 8'hF7);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) show_raw(3, 8'hD5, 40);
            else        show(i, 4'(i), 1'b0, 40);
        end
        check("t5_error_seen", exp_errs.size(), 0);

        // Watchdog expiry after a full frame
        expect_frame(32'h10FEDCBA, 8'h80, 8'hFF);
        for (int i = 0; i < 8; i++) show(i, 4'((i + 10) & 15), i == 7, 40);
        en  = 8'hFF;
        seg = 8'hFF;
        target = last_strobe_cyc + 253;
        for (int i = 0; i < 400 && cyc < target; i++) @(negedge clk);
        check("t6_wait_253", cyc, target);
        check("t6_valid_before_timeout", 32'(frame_valid), 32'd1);
        target = last_strobe_cyc + 256;
        for (int i = 0; i < 400 && cyc < target; i++) @(negedge clk);
        check("t6_wait_256", cyc, target);
        check("t6_valid_after_timeout", 32'(frame_valid), 32'd0);
        check("t6_data_holds", data, 32'h10FEDCBA);
        check("t6_dvalid_holds", 32'(dvalid), 32'hFF);
        @(posedge clk);
        #1;
        go_idle(50);

        // Reset in the middle of a partial frame
        for (int i = 0; i < 4; i++) show(i, 4'h5, 1'b1, 40);
        go_idle(1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_data", data, 32'h0);
        check("t6_rst_point", 32'(point), 32'h0);
        check("t6_rst_dvalid", 32'(dvalid), 32'h0);
        check("t6_rst_frame_valid", 32'(frame_valid), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        saved = strobes;
        for (int i = 4; i < 8; i++) show(i, 4'h6, 1'b0, 40);
        go_idle(40);
        check("t6_partial_discarded", strobes, saved);

        check("frames_outstanding", exp_frames.size(), 0);
        check("errors_outstanding", exp_errs.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
